ram_arbiter: RTL and testbench
==============================

# ram_arbiter

Single-port main-RAM arbiter shared by the instruction cache (read-only refills) and the data cache (write-back plus refill). Sits between both cache controllers and the RAM model. Serialises every RAM transaction and steers per-port grant (`UsingRAM`) and ready signals. Sequences a dirty-line eviction as an atomic write-back followed by a refill read.

## Interface
- `AW`, 32, address width.
- `DW`, 32, data width.
- `clock`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low; low forces all state to reset values.
- `instReadRAM`  in  1  instruction-cache refill request, level, held until served.
- `instAddress`  in  AW  instruction refill address.
- `instUsingRAM`  out  DW→1  grant to instruction port.
- `instReady`  out  1  instruction read data valid.
- `dataReadRAM`  in  1  data-cache refill request, level.
- `dataWriteRAM`  in  1  data-cache write-back request, level, dropped by requester once granted.
- `dataAddress`  in  AW  data-port address (victim address while `dataWriteRAM`, refill address otherwise).
- `dataValueRAM`  in  DW  write-back data.
- `dataUsingRAM`  out  1  grant to data port.
- `dataReady`  out  1  data read data valid.
- `outRAM`  out  DW  read data, broadcast to both ports (`ramData` pass-through).
- `ramRead`, `ramWrite`  out  1  RAM commands, held until `ramReady`.
- `ramAddress`  out  AW  latched transaction address.
- `ramWData`  out  DW  latched write data.
- `ramReady`  in  1  one-cycle completion pulse from RAM.
- `ramData`  in  DW  RAM read data, valid with `ramReady`.

## Operation
- States: IDLE, I_READ, D_WB, D_FILL, D_READ.
- IDLE: sample requests. Data request = `dataWriteRAM | dataReadRAM`; `dataWriteRAM` takes precedence over `dataReadRAM`. Both ports requesting: round-robin via 1-bit `lastGrant` (port not served last wins); `lastGrant` resets to instruction so data wins first conflict.
- On grant edge: latch `ramAddress` from requester address; latch `ramWData` from `dataValueRAM` for D_WB; update `lastGrant`.
- I_READ: `ramRead`=1; on `ramReady` -> IDLE.
- D_READ: `ramRead`=1; on `ramReady` -> IDLE.
- D_WB: `ramWrite`=1; on `ramReady` latch `ramAddress` <= `dataAddress` (refill address, requester has already dropped `dataWriteRAM`) -> D_FILL. No `dataReadRAM` required for this refill.
- D_FILL: `ramRead`=1; on `ramReady` -> IDLE.
- `instUsingRAM` = state==I_READ; `dataUsingRAM` = state in {D_WB, D_FILL, D_READ}; Moore, decoded from state register.
- `instReady` = `ramReady` & I_READ; `dataReady` = `ramReady` & (D_FILL | D_READ); write-completion `ramReady` in D_WB is never forwarded.
- `ramReady` in IDLE ignored. Requests arriving while busy wait; no queueing beyond the level request.

## Timing
- Reset values: state IDLE, `lastGrant`=inst, all command/grant/ready outputs 0, `ramAddress`/`ramWData` 0.
- Request high at edge N in IDLE -> grant and RAM command high from cycle N+1.
- Read latency = 1 + RAM latency; ready and data combinational pass-through same cycle as `ramReady`.
- Eviction: grant held continuously D_WB→D_FILL; no other port can interleave.
- Return to IDLE after ready edge; requester drops its request at that same edge, so no re-grant from stale request. Minimum one IDLE cycle between transactions.
- Reset asserted mid-transaction: immediate abort, commands drop asynchronously; RAM must tolerate abandoned command.

## Configuration
- `RAM_ARB_FIXED_PRIO_EN`: defined -> data port always wins conflicts in IDLE, `lastGrant` unused (instruction can starve). Undefined -> round-robin as above.

## Test plan
- Lone instruction read @0x100, RAM latency 3 -> `ramRead` cycles 1-4, `instReady`+`outRAM`=RAM word at cycle 4, `dataUsingRAM` never high.
- Both read same cycle (inst 0x40, data 0x80) after reset -> data served first, instruction granted second; repeat -> instruction first.
- Eviction: `dataWriteRAM`, victim 0x1000 data 0xDEADBEEF, refill 0x2000 -> write 0x1000/0xDEADBEEF, no `dataReady` on write ack, then read 0x2000, `dataReady` once.
- Instruction request during eviction -> waits until D_FILL completes, then granted.
- Reset low during D_FILL -> all outputs 0 same cycle, IDLE after release, fresh request served normally.
- `RAM_ARB_FIXED_PRIO_EN` defined, continuous data requests plus instruction request -> data granted every time.

Source files
------------

// File: rtl/ram_arbiter.sv
`default_nettype none
// ram_arbiter: serialises I-cache refills and D-cache write-back + refill onto one RAM port.
// Build option RAM_ARB_FIXED_PRIO_EN: data port always wins IDLE conflicts (rev 1.0).
module ram_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          instReadRAM,
    input  logic [AW-1:0] instAddress,
    output logic          instUsingRAM,
    output logic          instReady,
    input  logic          dataReadRAM,
    input  logic          dataWriteRAM,
    input  logic [AW-1:0] dataAddress,
    input  logic [DW-1:0] dataValueRAM,
    output logic          dataUsingRAM,
    output logic          dataReady,
    output logic [DW-1:0] outRAM,
    output logic          ramRead,
    output logic          ramWrite,
    output logic [AW-1:0] ramAddress,
    output logic [DW-1:0] ramWData,
    input  logic          ramReady,
    input  logic [DW-1:0] ramData
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_I_READ = 3'd1;
    localparam logic [2:0] S_D_WB   = 3'd2;
    localparam logic [2:0] S_D_FILL = 3'd3;
    localparam logic [2:0] S_D_READ = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          data_req;
    logic          data_wins;

    assign data_req = dataWriteRAM | dataReadRAM;

`ifdef RAM_ARB_FIXED_PRIO_EN
    assign data_wins = data_req;
`else
    localparam logic GRANT_INST = 1'b0;
    localparam logic GRANT_DATA = 1'b1;

    logic last_grant_q, last_grant_d;

    // Port not served last wins a conflict; reset value lets data win the first one.
    assign data_wins = data_req & (~instReadRAM | (last_grant_q == GRANT_INST));

    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == S_IDLE) begin
            if (data_wins) begin
                last_grant_d = GRANT_DATA;
            end else if (instReadRAM) begin
                last_grant_d = GRANT_INST;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant_q <= GRANT_INST;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (data_wins) begin
                    addr_d = dataAddress;
                    if (dataWriteRAM) begin
                        state_d = S_D_WB;
                        wdata_d = dataValueRAM;
                    end else begin
                        state_d = S_D_READ;
                    end
                end else if (instReadRAM) begin
                    state_d = S_I_READ;
                    addr_d  = instAddress;
                end
            end
            S_I_READ, S_D_READ, S_D_FILL: begin
                if (ramReady) begin
                    state_d = S_IDLE;
                end
            end
            S_D_WB: begin
                // Requester has already switched dataAddress to the refill line.
                if (ramReady) begin
                    state_d = S_D_FILL;
                    addr_d  = dataAddress;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        instUsingRAM = (state_q == S_I_READ);
        dataUsingRAM = (state_q == S_D_WB) || (state_q == S_D_FILL) || (state_q == S_D_READ);
        ramRead      = (state_q == S_I_READ) || (state_q == S_D_FILL) || (state_q == S_D_READ);
        ramWrite     = (state_q == S_D_WB);
        instReady    = ramReady && (state_q == S_I_READ);
        dataReady    = ramReady && ((state_q == S_D_FILL) || (state_q == S_D_READ));
    end

    assign outRAM     = ramData;
    assign ramAddress = addr_q;
    assign ramWData   = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// tb_ram_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_ram_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          instReadRAM = 1'b0;
    logic [AW-1:0] instAddress = '0;
    logic          dataReadRAM = 1'b0;
    logic          dataWriteRAM = 1'b0;
    logic [AW-1:0] dataAddress = '0;
    logic [DW-1:0] dataValueRAM = '0;
    logic          ramReady = 1'b0;
    logic [DW-1:0] ramData = '0;
    logic          instUsingRAM, instReady, dataUsingRAM, dataReady, ramRead, ramWrite;
    logic [DW-1:0] outRAM, ramWData;
    logic [AW-1:0] ramAddress;

    ram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clock(clock), .reset(reset),
        .instReadRAM(instReadRAM), .instAddress(instAddress),
        .instUsingRAM(instUsingRAM), .instReady(instReady),
        .dataReadRAM(dataReadRAM), .dataWriteRAM(dataWriteRAM),
        .dataAddress(dataAddress), .dataValueRAM(dataValueRAM),
        .dataUsingRAM(dataUsingRAM), .dataReady(dataReady),
        .outRAM(outRAM), .ramRead(ramRead), .ramWrite(ramWrite),
        .ramAddress(ramAddress), .ramWData(ramWData),
        .ramReady(ramReady), .ramData(ramData)
    );

    always #5 clock = ~clock;

    int chk_cnt  = 0;
    int fail_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding RAM operation owned by one port.
    logic        m_busy = 1'b0, m_data = 1'b0, m_write = 1'b0, m_last_data = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0;

    function automatic logic pick_data();
        logic dr;
        dr = dataWriteRAM || dataReadRAM;
`ifdef RAM_ARB_FIXED_PRIO_EN
        return dr;
`else
        return dr && (!instReadRAM || !m_last_data);
`endif
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_busy <= 1'b0; m_data <= 1'b0; m_write <= 1'b0; m_last_data <= 1'b0;
            m_addr <= '0; m_wdata <= '0;
        end else if (!m_busy) begin
            if (instReadRAM || dataWriteRAM || dataReadRAM) begin
                m_busy      <= 1'b1;
                m_data      <= pick_data();
                m_last_data <= pick_data();
                m_write     <= pick_data() && dataWriteRAM;
                m_addr      <= pick_data() ? dataAddress : instAddress;
                if (pick_data() && dataWriteRAM) m_wdata <= dataValueRAM;
            end
        end else if (ramReady) begin
            if (m_write) begin
                m_write <= 1'b0;
                m_addr  <= dataAddress;
            end else begin
                m_busy <= 1'b0;
            end
        end
    end

    bit cmp_en = 1'b0;
    always @(negedge clock) begin
        if (cmp_en && reset) begin
            check("m_instUsingRAM", instUsingRAM, m_busy && !m_data);
            check("m_dataUsingRAM", dataUsingRAM, m_busy && m_data);
            check("m_ramRead",      ramRead,      m_busy && !m_write);
            check("m_ramWrite",     ramWrite,     m_busy && m_write);
            check("m_instReady",    instReady,    m_busy && !m_data && ramReady);
            check("m_dataReady",    dataReady,    m_busy && m_data && !m_write && ramReady);
            check("m_ramAddress",   ramAddress,   m_addr);
            check("m_ramWData",     ramWData,     m_wdata);
            check("m_outRAM",       outRAM,       ramData);
        end
    end

    // RAM agent: contents default to a hash of the address until written.
    logic [31:0] mem [logic [31:0]];
    int fixed_lat = 3;
    bit spurious_en = 1'b0, rand_en = 1'b0;
    int ram_cnt = 0, ram_lat = 0;
    bit prev_cmd = 1'b0, prev_ram_ready = 1'b0, prev_inst_ready = 1'b0, prev_data_ready = 1'b0;

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic ram_agent();
        bit cmd;
        cmd = ramRead || ramWrite;
        if (prev_ram_ready || !prev_cmd) begin
            ram_cnt = 0;
            ram_lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
        end else begin
            ram_cnt++;
        end
        if (cmd) ramReady = (ram_cnt == ram_lat);
        else     ramReady = spurious_en && ($urandom_range(0, 7) == 0);
        if (ramReady && ramRead) ramData = ram_word(ramAddress);
        else                     ramData = $urandom;
        if (ramReady && ramWrite) mem[ramAddress] = ramWData;
        prev_cmd = cmd;
    endtask

    int d_phase = 0;
    logic [31:0] d_refill = '0;

    task automatic req_agents();
        if (instReadRAM) begin
            if (prev_inst_ready) instReadRAM = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
            instReadRAM = 1'b1;
            instAddress = $urandom & 32'hFFFF_FFFC;
        end
        case (d_phase)
            0: begin
                if ($urandom_range(0, 2) == 0) begin
                    dataAddress = $urandom & 32'hFFFF_FFFC;
                    if ($urandom_range(0, 1) == 0) begin
                        dataWriteRAM = 1'b1;
                        dataValueRAM = $urandom;
                        d_refill     = $urandom & 32'hFFFF_FFFC;
                        d_phase      = 1;
                    end else begin
                        dataReadRAM = 1'b1;
                        d_phase     = 2;
                    end
                end else begin
                    dataValueRAM = $urandom;
                end
            end
            1: if (dataUsingRAM) begin
                dataWriteRAM = 1'b0;
                dataAddress  = d_refill;
                dataValueRAM = $urandom;
                d_phase      = 2;
            end
            default: if (prev_data_ready) begin
                dataReadRAM = 1'b0;
                d_phase     = 0;
            end
        endcase
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (rand_en) req_agents();
        ram_agent();
        #1;
        prev_ram_ready  = ramReady;
        prev_inst_ready = instReady;
        prev_data_ready = dataReady;
    endtask

    function automatic logic probe(input int sel);
        case (sel)
            0: return instReady;
            1: return dataReady;
            2: return instUsingRAM;
            3: return dataUsingRAM;
            4: return ramRead;
            default: return ramReady;
        endcase
    endfunction

    task automatic wait_until(input int sel, input string nm);
        int n = 0;
        while (!probe(sel) && n < 40) begin
            tick();
            n++;
        end
        chk_cnt++;
        if (n >= 40) begin
            fail_cnt++;
            $display("FAIL %s: timeout after %0d cycles, required signal high", nm, n);
        end
    endtask

    initial begin
        int n, drc;
        #2 reset = 1'b0;
        #1;
        check("rst_ramRead", ramRead, 0);
        check("rst_ramWrite", ramWrite, 0);
        check("rst_instUsing", instUsingRAM, 0);
        check("rst_dataUsing", dataUsingRAM, 0);
        check("rst_ramAddress", ramAddress, 0);
        check("rst_ramWData", ramWData, 0);
        @(posedge clock);
        #2 reset = 1'b1;
        cmp_en = 1'b1;

        // Lone instruction read, RAM latency 3
        fixed_lat = 3;
        instReadRAM = 1'b1; instAddress = 32'h100;
        for (int c = 1; c <= 5; c++) begin
            tick();
            check("A_ramRead", ramRead, c <= 4);
            check("A_instReady", instReady, c == 4);
            check("A_dataUsing", dataUsingRAM, 0);
            if (c == 1) check("A_addr", ramAddress, 32'h100);
            if (c == 4) begin
                check("A_outRAM", outRAM, 32'h5A5A_0100);
                instReadRAM = 1'b0;
            end
        end

        // Simultaneous reads: data wins the first conflict
        fixed_lat = 1;
        instReadRAM = 1'b1; instAddress = 32'h40;
        dataReadRAM = 1'b1; dataAddress = 32'h80;
        tick();
        check("B1_dataUsing", dataUsingRAM, 1);
        check("B1_instUsing", instUsingRAM, 0);
        check("B1_addr", ramAddress, 32'h80);
        wait_until(1, "B1_dataReady");
        check("B1_outRAM", outRAM, 32'h5A5A_0080);
        dataAddress = 32'h84;
        tick();
        check("B_idle_gap", ramRead, 0);
        tick();
`ifdef RAM_ARB_FIXED_PRIO_EN
        check("B2_dataUsing", dataUsingRAM, 1);
        check("B2_addr", ramAddress, 32'h84);
        wait_until(1, "B2_dataReady");
        dataAddress = 32'h88;
        tick(); tick();
        check("B3_dataUsing", dataUsingRAM, 1);
        check("B3_addr", ramAddress, 32'h88);
        wait_until(1, "B3_dataReady");
        dataReadRAM = 1'b0;
        tick(); tick();
        check("B4_instUsing", instUsingRAM, 1);
        check("B4_addr", ramAddress, 32'h40);
        wait_until(0, "B4_instReady");
        instReadRAM = 1'b0;
`else
        check("B2_instUsing", instUsingRAM, 1);
        check("B2_addr", ramAddress, 32'h40);
        wait_until(0, "B2_instReady");
        instReadRAM = 1'b0;
        tick(); tick();
        check("B3_dataUsing", dataUsingRAM, 1);
        check("B3_addr", ramAddress, 32'h84);
        wait_until(1, "B3_dataReady");
        dataReadRAM = 1'b0;
`endif

        // Eviction with an instruction request arriving mid-eviction
        fixed_lat = 2;
        dataWriteRAM = 1'b1; dataAddress = 32'h1000; dataValueRAM = 32'hDEAD_BEEF;
        tick(); tick();
        check("C_ramWrite", ramWrite, 1);
        check("C_wb_addr", ramAddress, 32'h1000);
        check("C_wb_data", ramWData, 32'hDEAD_BEEF);
        dataWriteRAM = 1'b0; dataAddress = 32'h2000; dataValueRAM = '0;
        instReadRAM = 1'b1; instAddress = 32'h300;
        wait_until(5, "C_wb_ack");
        check("C_wb_noReady", dataReady, 0);
        tick();
        check("C_fill_read", ramRead, 1);
        check("C_fill_addr", ramAddress, 32'h2000);
        check("C_fill_instUsing", instUsingRAM, 0);
        n = 0; drc = 0;
        while (!instUsingRAM && n < 20) begin
            if (dataReady) begin
                drc++;
                check("C_fill_data", outRAM, 32'h5A5A_2000);
            end
            tick();
            n++;
        end
        check("C_dataReady_count", drc, 1);
        check("C_inst_after", ramAddress, 32'h300);
        wait_until(0, "C_instReady");
        instReadRAM = 1'b0;

        // Reset asserted during the refill
        fixed_lat = 3;
        dataWriteRAM = 1'b1; dataAddress = 32'h1100; dataValueRAM = 32'h1234_5678;
        wait_until(3, "D_grant");
        dataWriteRAM = 1'b0; dataAddress = 32'h2100;
        wait_until(4, "D_fill");
        tick();
        #1 reset = 1'b0;
        #1;
        check("D_rst_ramRead", ramRead, 0);
        check("D_rst_dataUsing", dataUsingRAM, 0);
        check("D_rst_ramAddress", ramAddress, 0);
        check("D_rst_ramWData", ramWData, 0);
        ramReady = 1'b0; prev_cmd = 1'b0; prev_ram_ready = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        check("D_idle_after", dataUsingRAM, 0);
        fixed_lat = 1;
        instReadRAM = 1'b1; instAddress = 32'h500;
        tick(); tick();
        check("D_new_instUsing", instUsingRAM, 1);
        check("D_new_addr", ramAddress, 32'h500);
        wait_until(0, "D_new_instReady");
        check("D_new_data", outRAM, 32'h5A5A_0500);
        instReadRAM = 1'b0;

        // Randomized traffic
        tick();
        d_phase = 0;
        fixed_lat = -1;
        spurious_en = 1'b1;
        rand_en = 1'b1;
        for (int i = 0; i < 4000; i++) tick();

        $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
        $finish;
    end

endmodule
`default_nettype wire
